load_store_unit: RTL and testbench
==================================

# load_store_unit

Sits between the execute stage and `data_memory`. Accepts one load or store request at a time over a valid/ready handshake. Converts byte and halfword accesses into whole-word memory operations: read-modify-write for sub-word stores, lane extraction plus sign or zero extension for loads. Returns a single response per request, carrying an alignment error flag.

## Interface
- `address_width`, 32, byte address width
- `word_width`, 32, data word width; fixed at 32 (byte-lane logic assumes four lanes)

Ports:
- `clock` in 1: rising-edge clock
- `reset_n` in 1: asynchronous, active-low reset
- `request_valid` in 1: request offered
- `request_ready` out 1: unit can accept a request
- `request_write` in 1: 1 = store, 0 = load
- `request_size` in 2: 00 byte, 01 halfword, 10 word, 11 illegal
- `request_unsigned` in 1: loads only; 1 = zero-extend, 0 = sign-extend
- `request_address` in `address_width`: byte address
- `request_data` in 32: store data; the value sits in the low bits for sub-word sizes
- `response_valid` out 1: response available
- `response_ready` in 1: consumer takes the response
- `response_data` out 32: extended load data; 0 for stores and errors
- `response_error` out 1: misaligned or illegal-size request
- `memory_address` out `address_width`: to `data_memory` address
- `memory_write_enable` out 1: to `data_memory` write enable
- `memory_write_data` out 32: to `data_memory` write data
- `memory_read_data` in 32: from `data_memory`; combinational read of `memory_address`

## Operation
- FSM states and meaning:
  - IDLE: `request_ready` = 1
  - READ: capture `memory_read_data` into the word register
  - WRITE: `memory_write_enable` = 1
  - RESPOND: `response_valid` = 1
- Accept occurs when `request_valid` && `request_ready`. On accept, latch write, size, unsigned, address and data.
- Misaligned cases:
  - halfword with addr[0] = 1
  - word with addr[1:0] ≠ 0
  - size 11
- Misaligned request: IDLE→RESPOND with `response_error` = 1. Memory is never written.
- Load: IDLE→READ→RESPOND. In READ, register the selected lane, extended per `request_unsigned`.
- Word store: IDLE→WRITE→RESPOND. `memory_write_data` = latched data.
- Byte/halfword store: IDLE→READ→WRITE→RESPOND.
  - WRITE data is the captured word with the target lane replaced.
  - All other lanes are preserved bit-exact.
- Lane mapping is little-endian:
  - byte lane k = addr[1:0], bits [8k+7:8k]
  - halfword lane = addr[1], bits [16h+15:16h]
- RESPOND holds `response_valid`, `response_data` and `response_error` stable until `response_ready`. The handshake cycle returns to IDLE.
- `memory_address` = latched address, registered on accept. Low two bits are passed through; `data_memory` word-aligns.

## Timing
- Reset values:
  - state IDLE
  - `request_ready` 1
  - `response_valid` 0
  - `response_error` 0
  - `response_data` 0
  - `memory_write_enable` 0
  - `memory_address` 0
  - `memory_write_data` 0
- Latency from the accept edge to `response_valid` high (when `response_ready` is held at 1):
  - error: 1 cycle
  - load: 2 cycles
  - word store: 2 cycles
  - sub-word store: 3 cycles
- Memory timing:
  - `memory_write_enable` is high for exactly one cycle per store.
  - The write commits at the rising edge that ends WRITE.
- No pipelining. `request_ready` is 0 from the accept edge until the response handshake completes. A new request is accepted no earlier than the cycle after the response handshake.
- `request_*` inputs are ignored outside the accept cycle; changing them mid-operation has no effect.
- Reset asserted mid-operation:
  - return to IDLE immediately (asynchronously)
  - `memory_write_enable` drops immediately
  - the in-flight request is discarded; no response is issued
  - a write is performed only if its commit edge occurred before reset assertion

## Structure
- Package `lsu_pkg` holds:
  - `access_size_t` enum (BYTE = 2'b00, HALF = 2'b01, WORD = 2'b10)
  - `lsu_state_t` enum (IDLE, READ, WRITE, RESPOND)
  - a function `is_misaligned(size, addr[1:0])`
- Sub-module `lane_merge` is combinational, with two functions:
  - merge: (old word, new data, size, addr[1:0]) → merged store word
  - extract: (word, size, addr[1:0], unsigned) → extended load value
- The top level holds only the FSM and registers.

## Test plan
- Word store 0xDEADBEEF to 0x10, then load word from 0x10 → response_data 0xDEADBEEF, error 0; latencies 2 and 2.
- Memory word 0x11223344 at 0x20; store byte 0xAA to 0x21 → memory becomes 0x1122AA44. `memory_write_enable` is high in exactly one cycle; latency is 3.
- Memory 0x80FF7F01 at 0x30:
  - signed byte load from 0x33 → 0xFFFFFF80
  - unsigned byte load from 0x33 → 0x00000080
  - signed half load from 0x30 → 0x00007F01
- Half store to 0x41 and word load from 0x42 → `response_error` 1 after 1 cycle, no write-enable pulse, memory unchanged.
- Hold `response_ready` low for 4 cycles during RESPOND → outputs stable and `request_ready` 0 throughout; the next request is accepted only after the handshake.
- Assert `reset_n` low while a sub-word store is in READ → no write-enable pulse, memory unchanged, no response; all outputs take their reset values.

Source files
------------

// File: rtl/lsu_pkg.sv
// ---------------------------------------------------------------------------
// lsu_pkg
// Shared types and helpers for the load/store unit.
//   access_size_t : encoding of request_size (11 is an illegal size)
//   lsu_state_t   : controller states
//   is_misaligned : flags accesses that cannot be served as one word operation
// ---------------------------------------------------------------------------
package lsu_pkg;

    typedef enum logic [1:0] {
        BYTE = 2'b00,
        HALF = 2'b01,
        WORD = 2'b10
    } access_size_t;

    typedef enum logic [1:0] {
        IDLE    = 2'b00,
        READ    = 2'b01,
        WRITE   = 2'b10,
        RESPOND = 2'b11
    } lsu_state_t;

    // Size 11 is treated as misaligned so that it takes the error path.
    function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] addr_lo);
        logic bad;
        case (size)
            BYTE:    bad = 1'b0;
            HALF:    bad = addr_lo[0];
            WORD:    bad = (addr_lo != 2'b00);
            default: bad = 1'b1;
        endcase
        return bad;
    endfunction

endpackage

// File: rtl/load_store_unit_if.sv
// ---------------------------------------------------------------------------
// load_store_unit_if
// Request/response handshake between the execute stage (master) and the
// load/store unit (slave).
//   request_*  : one load/store offered under request_valid/request_ready
//   response_* : one result returned under response_valid/response_ready
// ---------------------------------------------------------------------------
interface load_store_unit_if #(
    parameter int address_width = 32
) ();
    logic                     request_valid;
    logic                     request_ready;
    logic                     request_write;
    logic [1:0]               request_size;
    logic                     request_unsigned;
    logic [address_width-1:0] request_address;
    logic [31:0]              request_data;
    logic                     response_valid;
    logic                     response_ready;
    logic [31:0]              response_data;
    logic                     response_error;

    modport master (
        output request_valid, request_write, request_size, request_unsigned,
               request_address, request_data, response_ready,
        input  request_ready, response_valid, response_data, response_error
    );

    modport slave (
        input  request_valid, request_write, request_size, request_unsigned,
               request_address, request_data, response_ready,
        output request_ready, response_valid, response_data, response_error
    );
endinterface

// File: rtl/lane_merge.sv
// ---------------------------------------------------------------------------
// lane_merge
// Combinational byte-lane logic for a little-endian 32-bit word.
//   old_word    : word currently in memory
//   new_data    : store data, value in the low bits for sub-word sizes
//   size        : access size (BYTE/HALF/WORD)
//   addr_lo     : byte offset within the word
//   is_unsigned : 1 = zero-extend loads, 0 = sign-extend
//   merged      : old_word with the addressed lane replaced by new_data
//   extracted   : addressed lane of old_word, extended to 32 bits
// ---------------------------------------------------------------------------
module lane_merge
    import lsu_pkg::*;
(
    input  logic [31:0] old_word,
    input  logic [31:0] new_data,
    input  logic [1:0]  size,
    input  logic [1:0]  addr_lo,
    input  logic        is_unsigned,
    output logic [31:0] merged,
    output logic [31:0] extracted
);

    function automatic logic [31:0] merge(input logic [31:0] word, input logic [31:0] data,
                                          input logic [1:0] sz, input logic [1:0] lo);
        logic [31:0] w;
        w = word;
        case (sz)
            BYTE:    w[{lo, 3'b000} +: 8]     = data[7:0];
            HALF:    w[{lo[1], 4'b0000} +: 16] = data[15:0];
            default: w = data;
        endcase
        return w;
    endfunction

    function automatic logic [31:0] extract(input logic [31:0] word, input logic [1:0] sz,
                                            input logic [1:0] lo, input logic uns);
        logic signed [7:0]  lane_b;
        logic signed [15:0] lane_h;
        logic [31:0]        r;
        lane_b = word[{lo, 3'b000} +: 8];
        lane_h = word[{lo[1], 4'b0000} +: 16];
        case (sz)
            BYTE:    r = uns ? {24'd0, lane_b} : {{24{lane_b[7]}}, lane_b};
            HALF:    r = uns ? {16'd0, lane_h} : {{16{lane_h[15]}}, lane_h};
            default: r = word;
        endcase
        return r;
    endfunction

    assign merged    = merge(old_word, new_data, size, addr_lo);
    assign extracted = extract(old_word, size, addr_lo, is_unsigned);

endmodule

// File: rtl/load_store_unit.sv
// ---------------------------------------------------------------------------
// load_store_unit
// Serves one load or store at a time against a combinational-read word
// memory. Sub-word stores are done as read-modify-write; loads return the
// addressed lane sign- or zero-extended. Misaligned or illegal-size requests
// return an error response without touching memory.
//   clock, reset_n      : rising-edge clock, asynchronous active-low reset
//   bus                 : request/response handshake (slave side)
//   memory_address      : latched request address (low bits passed through)
//   memory_write_enable : high only in WRITE, one cycle per store
//   memory_write_data   : word to commit at the edge that ends WRITE
//   memory_read_data    : combinational read of memory_address
// ---------------------------------------------------------------------------
module load_store_unit
    import lsu_pkg::*;
#(
    parameter int address_width = 32,
    parameter int word_width    = 32
) (
    input  logic                     clock,
    input  logic                     reset_n,
    load_store_unit_if.slave         bus,
    output logic [address_width-1:0] memory_address,
    output logic                     memory_write_enable,
    output logic [word_width-1:0]    memory_write_data,
    input  logic [word_width-1:0]    memory_read_data
);

    lsu_state_t            state, next_state;
    logic                  accept;
    logic                  misaligned;
    logic                  op_write;
    logic [1:0]            op_size;
    logic                  op_unsigned;
    logic [word_width-1:0] op_data;
    logic [word_width-1:0] resp_data;
    logic                  resp_error;
    logic [31:0]           merged_word;
    logic [31:0]           extracted_word;

    lane_merge u_lane_merge (
        .old_word    (memory_read_data),
        .new_data    (op_data),
        .size        (op_size),
        .addr_lo     (memory_address[1:0]),
        .is_unsigned (op_unsigned),
        .merged      (merged_word),
        .extracted   (extracted_word)
    );

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        accept     = 1'b0;
        misaligned = is_misaligned(bus.request_size, bus.request_address[1:0]);
        case (state)
            IDLE: begin
                if (bus.request_valid) begin
                    accept = 1'b1;
                    if (misaligned) begin
                        next_state = RESPOND;
                    end else if (bus.request_write && bus.request_size == WORD) begin
                        next_state = WRITE;
                    end else begin
                        // Loads and sub-word stores both need the current word first.
                        next_state = READ;
                    end
                end
            end
            READ:    next_state = op_write ? WRITE : RESPOND;
            WRITE:   next_state = RESPOND;
            RESPOND: if (bus.response_ready) next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // Request latch on accept; READ stage registers either the merged store
    // word or the extended load value from the freshly read memory word.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            op_write          <= 1'b0;
            op_size           <= 2'b00;
            op_unsigned       <= 1'b0;
            op_data           <= '0;
            memory_address    <= '0;
            memory_write_data <= '0;
            resp_data         <= '0;
            resp_error        <= 1'b0;
        end else begin
            if (accept) begin
                op_write       <= bus.request_write;
                op_size        <= bus.request_size;
                op_unsigned    <= bus.request_unsigned;
                op_data        <= bus.request_data;
                memory_address <= bus.request_address;
                resp_error     <= misaligned;
                // Stores and errors report zero data.
                resp_data      <= '0;
                if (bus.request_write && bus.request_size == WORD) begin
                    memory_write_data <= bus.request_data;
                end
            end
            if (state == READ) begin
                if (op_write) begin
                    memory_write_data <= merged_word;
                end else begin
                    resp_data <= extracted_word;
                end
            end
        end
    end

    assign bus.request_ready   = (state == IDLE);
    assign bus.response_valid  = (state == RESPOND);
    assign bus.response_data   = resp_data;
    assign bus.response_error  = resp_error;
    assign memory_write_enable = (state == WRITE);

endmodule

// File: tb/tb_load_store_unit.sv
// ---------------------------------------------------------------------------
// tb_load_store_unit
// Directed bench for load_store_unit with a small word memory standing in
// for data_memory (combinational read, write on the rising edge).
// ---------------------------------------------------------------------------
module tb_load_store_unit;

    logic        clock = 1'b0;
    logic        reset_n;
    logic [31:0] memory_address;
    logic        memory_write_enable;
    logic [31:0] memory_write_data;
    logic [31:0] memory_read_data;

    logic [31:0] mem [64];
    logic        pl_en = 1'b0;
    logic [5:0]  pl_idx = '0;
    logic [31:0] pl_val = '0;
    int          we_count = 0;

    int n_cmp  = 0;
    int n_fail = 0;

    load_store_unit_if #(.address_width(32)) bus ();

    load_store_unit #(.address_width(32), .word_width(32)) dut (
        .clock               (clock),
        .reset_n             (reset_n),
        .bus                 (bus),
        .memory_address      (memory_address),
        .memory_write_enable (memory_write_enable),
        .memory_write_data   (memory_write_data),
        .memory_read_data    (memory_read_data)
    );

    always #5 clock = ~clock;

    assign memory_read_data = mem[memory_address[7:2]];

    always @(posedge clock) begin
        if (memory_write_enable) begin
            mem[memory_address[7:2]] <= memory_write_data;
            we_count <= we_count + 1;
        end else if (pl_en) begin
            mem[pl_idx] <= pl_val;
        end
    end

    task automatic preload(input logic [5:0] idx, input logic [31:0] val);
        @(negedge clock);
        pl_en  = 1'b1;
        pl_idx = idx;
        pl_val = val;
        @(negedge clock);
        pl_en  = 1'b0;
    endtask

    // One full transaction with response_ready held high. Request inputs are
    // scrambled right after the accept edge; the unit must ignore them.
    task automatic do_req(input logic wr, input logic [1:0] sz, input logic uns,
                          input logic [31:0] addr, input logic [31:0] data,
                          output int lat, output logic [31:0] rdata,
                          output logic rerr, output int pulses);
        int we0;
        @(negedge clock);
        bus.request_valid    = 1'b1;
        bus.request_write    = wr;
        bus.request_size     = sz;
        bus.request_unsigned = uns;
        bus.request_address  = addr;
        bus.request_data     = data;
        we0 = we_count;
        @(posedge clock); #1;
        bus.request_valid    = 1'b0;
        bus.request_write    = ~wr;
        bus.request_size     = 2'b10;
        bus.request_unsigned = ~uns;
        bus.request_address  = 32'h0000_00FC;
        bus.request_data     = 32'hA5A5_A5A5;
        n_cmp++;
        if (memory_address !== addr) begin
            n_fail++;
            $display("FAIL mem_addr: got %h want %h", memory_address, addr);
        end
        lat = 1;
        while (!bus.response_valid && lat < 8) begin
            @(posedge clock); #1;
            lat++;
        end
        rdata = bus.response_data;
        rerr  = bus.response_error;
        @(posedge clock); #1;
        pulses = we_count - we0;
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        #12;
        n_cmp++; if (bus.request_ready !== 1'b1) begin n_fail++; $display("FAIL rst_req_ready: got %b want 1", bus.request_ready); end
        n_cmp++; if (bus.response_valid !== 1'b0) begin n_fail++; $display("FAIL rst_rsp_valid: got %b want 0", bus.response_valid); end
        n_cmp++; if (bus.response_error !== 1'b0) begin n_fail++; $display("FAIL rst_rsp_error: got %b want 0", bus.response_error); end
        n_cmp++; if (bus.response_data !== 32'h0) begin n_fail++; $display("FAIL rst_rsp_data: got %h want 0", bus.response_data); end
        n_cmp++; if (memory_write_enable !== 1'b0) begin n_fail++; $display("FAIL rst_we: got %b want 0", memory_write_enable); end
        n_cmp++; if (memory_address !== 32'h0) begin n_fail++; $display("FAIL rst_addr: got %h want 0", memory_address); end
        n_cmp++; if (memory_write_data !== 32'h0) begin n_fail++; $display("FAIL rst_wdata: got %h want 0", memory_write_data); end
        @(negedge clock);
        reset_n = 1'b1;
        @(posedge clock); #1;
        n_cmp++; if (bus.request_ready !== 1'b1) begin n_fail++; $display("FAIL post_rst_ready: got %b want 1", bus.request_ready); end
    endtask

    task automatic test_word_store_load();
        int lat, pulses;
        logic [31:0] rd;
        logic er;
        do_req(1'b1, 2'b10, 1'b0, 32'h10, 32'hDEAD_BEEF, lat, rd, er, pulses);
        n_cmp++; if (lat !== 2) begin n_fail++; $display("FAIL sw_lat: got %0d want 2", lat); end
        n_cmp++; if (er !== 1'b0) begin n_fail++; $display("FAIL sw_err: got %b want 0", er); end
        n_cmp++; if (rd !== 32'h0) begin n_fail++; $display("FAIL sw_data: got %h want 0", rd); end
        n_cmp++; if (pulses !== 1) begin n_fail++; $display("FAIL sw_we: got %0d want 1", pulses); end
        n_cmp++; if (mem[4] !== 32'hDEAD_BEEF) begin n_fail++; $display("FAIL sw_mem: got %h want deadbeef", mem[4]); end
        do_req(1'b0, 2'b10, 1'b0, 32'h10, 32'h0, lat, rd, er, pulses);
        n_cmp++; if (lat !== 2) begin n_fail++; $display("FAIL lw_lat: got %0d want 2", lat); end
        n_cmp++; if (rd !== 32'hDEAD_BEEF) begin n_fail++; $display("FAIL lw_data: got %h want deadbeef", rd); end
        n_cmp++; if (er !== 1'b0) begin n_fail++; $display("FAIL lw_err: got %b want 0", er); end
        n_cmp++; if (pulses !== 0) begin n_fail++; $display("FAIL lw_we: got %0d want 0", pulses); end
    endtask

    task automatic test_subword_store();
        int lat, pulses;
        logic [31:0] rd;
        logic er;
        preload(6'd8, 32'h1122_3344);
        do_req(1'b1, 2'b00, 1'b0, 32'h21, 32'h1234_56AA, lat, rd, er, pulses);
        n_cmp++; if (lat !== 3) begin n_fail++; $display("FAIL sb_lat: got %0d want 3", lat); end
        n_cmp++; if (pulses !== 1) begin n_fail++; $display("FAIL sb_we: got %0d want 1", pulses); end
        n_cmp++; if (er !== 1'b0) begin n_fail++; $display("FAIL sb_err: got %b want 0", er); end
        n_cmp++; if (mem[8] !== 32'h1122_AA44) begin n_fail++; $display("FAIL sb_mem: got %h want 1122aa44", mem[8]); end
        do_req(1'b1, 2'b01, 1'b0, 32'h22, 32'h0000_BEEF, lat, rd, er, pulses);
        n_cmp++; if (mem[8] !== 32'hBEEF_AA44) begin n_fail++; $display("FAIL sh_mem: got %h want beefaa44", mem[8]); end
        n_cmp++; if (pulses !== 1) begin n_fail++; $display("FAIL sh_we: got %0d want 1", pulses); end
        do_req(1'b1, 2'b00, 1'b0, 32'h23, 32'h0000_005A, lat, rd, er, pulses);
        n_cmp++; if (mem[8] !== 32'h5AEF_AA44) begin n_fail++; $display("FAIL sb3_mem: got %h want 5aefaa44", mem[8]); end
        do_req(1'b1, 2'b01, 1'b0, 32'h20, 32'hFFFF_0F0F, lat, rd, er, pulses);
        n_cmp++; if (mem[8] !== 32'h5AEF_0F0F) begin n_fail++; $display("FAIL sh0_mem: got %h want 5aef0f0f", mem[8]); end
    endtask

    task automatic test_loads();
        int lat, pulses;
        logic [31:0] rd;
        logic er;
        preload(6'd12, 32'h80FF_7F01);
        do_req(1'b0, 2'b00, 1'b0, 32'h33, 32'h0, lat, rd, er, pulses);
        n_cmp++; if (rd !== 32'hFFFF_FF80) begin n_fail++; $display("FAIL lb_s33: got %h want ffffff80", rd); end
        n_cmp++; if (lat !== 2) begin n_fail++; $display("FAIL lb_lat: got %0d want 2", lat); end
        do_req(1'b0, 2'b00, 1'b1, 32'h33, 32'h0, lat, rd, er, pulses);
        n_cmp++; if (rd !== 32'h0000_0080) begin n_fail++; $display("FAIL lb_u33: got %h want 00000080", rd); end
        do_req(1'b0, 2'b01, 1'b0, 32'h30, 32'h0, lat, rd, er, pulses);
        n_cmp++; if (rd !== 32'h0000_7F01) begin n_fail++; $display("FAIL lh_s30: got %h want 00007f01", rd); end
        do_req(1'b0, 2'b01, 1'b0, 32'h32, 32'h0, lat, rd, er, pulses);
        n_cmp++; if (rd !== 32'hFFFF_80FF) begin n_fail++; $display("FAIL lh_s32: got %h want ffff80ff", rd); end
        do_req(1'b0, 2'b01, 1'b1, 32'h32, 32'h0, lat, rd, er, pulses);
        n_cmp++; if (rd !== 32'h0000_80FF) begin n_fail++; $display("FAIL lh_u32: got %h want 000080ff", rd); end
        do_req(1'b0, 2'b00, 1'b0, 32'h31, 32'h0, lat, rd, er, pulses);
        n_cmp++; if (rd !== 32'h0000_007F) begin n_fail++; $display("FAIL lb_s31: got %h want 0000007f", rd); end
        do_req(1'b0, 2'b00, 1'b0, 32'h32, 32'h0, lat, rd, er, pulses);
        n_cmp++; if (rd !== 32'hFFFF_FFFF) begin n_fail++; $display("FAIL lb_s32: got %h want ffffffff", rd); end
        do_req(1'b0, 2'b00, 1'b1, 32'h30, 32'h0, lat, rd, er, pulses);
        n_cmp++; if (rd !== 32'h0000_0001) begin n_fail++; $display("FAIL lb_u30: got %h want 00000001", rd); end
        n_cmp++; if (pulses !== 0) begin n_fail++; $display("FAIL ld_we: got %0d want 0", pulses); end
    endtask

    task automatic test_misaligned();
        int lat, pulses;
        logic [31:0] rd;
        logic er;
        preload(6'd16, 32'hCAFE_F00D);
        do_req(1'b1, 2'b01, 1'b0, 32'h41, 32'h0000_1234, lat, rd, er, pulses);
        n_cmp++; if (er !== 1'b1) begin n_fail++; $display("FAIL mh_err: got %b want 1", er); end
        n_cmp++; if (lat !== 1) begin n_fail++; $display("FAIL mh_lat: got %0d want 1", lat); end
        n_cmp++; if (pulses !== 0) begin n_fail++; $display("FAIL mh_we: got %0d want 0", pulses); end
        n_cmp++; if (mem[16] !== 32'hCAFE_F00D) begin n_fail++; $display("FAIL mh_mem: got %h want cafef00d", mem[16]); end
        do_req(1'b0, 2'b10, 1'b0, 32'h42, 32'h0, lat, rd, er, pulses);
        n_cmp++; if (er !== 1'b1) begin n_fail++; $display("FAIL mw_err: got %b want 1", er); end
        n_cmp++; if (lat !== 1) begin n_fail++; $display("FAIL mw_lat: got %0d want 1", lat); end
        n_cmp++; if (rd !== 32'h0) begin n_fail++; $display("FAIL mw_data: got %h want 0", rd); end
        do_req(1'b0, 2'b11, 1'b0, 32'h40, 32'h0, lat, rd, er, pulses);
        n_cmp++; if (er !== 1'b1) begin n_fail++; $display("FAIL ms_err: got %b want 1", er); end
        do_req(1'b1, 2'b10, 1'b0, 32'h43, 32'h0BAD_0BAD, lat, rd, er, pulses);
        n_cmp++; if (er !== 1'b1) begin n_fail++; $display("FAIL mws_err: got %b want 1", er); end
        n_cmp++; if (pulses !== 0) begin n_fail++; $display("FAIL mws_we: got %0d want 0", pulses); end
        n_cmp++; if (mem[16] !== 32'hCAFE_F00D) begin n_fail++; $display("FAIL mws_mem: got %h want cafef00d", mem[16]); end
        do_req(1'b0, 2'b10, 1'b0, 32'h40, 32'h0, lat, rd, er, pulses);
        n_cmp++; if (er !== 1'b0) begin n_fail++; $display("FAIL al_err: got %b want 0", er); end
    endtask

    task automatic test_backpressure();
        int lat;
        bus.response_ready = 1'b0;
        @(negedge clock);
        bus.request_valid    = 1'b1;
        bus.request_write    = 1'b0;
        bus.request_size     = 2'b10;
        bus.request_unsigned = 1'b0;
        bus.request_address  = 32'h10;
        bus.request_data     = 32'h0;
        @(posedge clock); #1;
        // A second, misaligned request is offered while the first is busy.
        bus.request_write   = 1'b1;
        bus.request_size    = 2'b01;
        bus.request_address = 32'h41;
        bus.request_data    = 32'h0000_1234;
        lat = 1;
        while (!bus.response_valid && lat < 8) begin
            @(posedge clock); #1;
            lat++;
        end
        n_cmp++; if (lat !== 2) begin n_fail++; $display("FAIL bp_lat: got %0d want 2", lat); end
        for (int i = 0; i < 4; i++) begin
            @(posedge clock); #1;
            n_cmp++; if (bus.response_valid !== 1'b1) begin n_fail++; $display("FAIL bp_valid[%0d]: got %b want 1", i, bus.response_valid); end
            n_cmp++; if (bus.response_data !== 32'hDEAD_BEEF) begin n_fail++; $display("FAIL bp_data[%0d]: got %h want deadbeef", i, bus.response_data); end
            n_cmp++; if (bus.response_error !== 1'b0) begin n_fail++; $display("FAIL bp_err[%0d]: got %b want 0", i, bus.response_error); end
            n_cmp++; if (bus.request_ready !== 1'b0) begin n_fail++; $display("FAIL bp_ready[%0d]: got %b want 0", i, bus.request_ready); end
        end
        @(negedge clock);
        bus.response_ready = 1'b1;
        @(posedge clock); #1;
        n_cmp++; if (bus.response_valid !== 1'b0) begin n_fail++; $display("FAIL bp_hs_valid: got %b want 0", bus.response_valid); end
        n_cmp++; if (bus.request_ready !== 1'b1) begin n_fail++; $display("FAIL bp_hs_ready: got %b want 1", bus.request_ready); end
        @(posedge clock); #1;
        bus.request_valid = 1'b0;
        n_cmp++; if (bus.request_ready !== 1'b0) begin n_fail++; $display("FAIL bp_next_ready: got %b want 0", bus.request_ready); end
        n_cmp++; if (bus.response_valid !== 1'b1) begin n_fail++; $display("FAIL bp_next_valid: got %b want 1", bus.response_valid); end
        n_cmp++; if (bus.response_error !== 1'b1) begin n_fail++; $display("FAIL bp_next_err: got %b want 1", bus.response_error); end
        @(posedge clock); #1;
    endtask

    task automatic test_reset_mid();
        int we0;
        preload(6'd20, 32'h5566_7788);
        @(negedge clock);
        we0 = we_count;
        bus.request_valid    = 1'b1;
        bus.request_write    = 1'b1;
        bus.request_size     = 2'b00;
        bus.request_unsigned = 1'b0;
        bus.request_address  = 32'h51;
        bus.request_data     = 32'h0000_0099;
        @(posedge clock); #1;
        bus.request_valid = 1'b0;
        n_cmp++; if (bus.request_ready !== 1'b0) begin n_fail++; $display("FAIL rm_busy: got %b want 0", bus.request_ready); end
        #1;
        reset_n = 1'b0;
        #1;
        n_cmp++; if (bus.request_ready !== 1'b1) begin n_fail++; $display("FAIL rm_ready: got %b want 1", bus.request_ready); end
        n_cmp++; if (memory_write_enable !== 1'b0) begin n_fail++; $display("FAIL rm_we: got %b want 0", memory_write_enable); end
        n_cmp++; if (memory_address !== 32'h0) begin n_fail++; $display("FAIL rm_addr: got %h want 0", memory_address); end
        n_cmp++; if (memory_write_data !== 32'h0) begin n_fail++; $display("FAIL rm_wdata: got %h want 0", memory_write_data); end
        n_cmp++; if (bus.response_valid !== 1'b0) begin n_fail++; $display("FAIL rm_valid: got %b want 0", bus.response_valid); end
        repeat (3) @(posedge clock);
        @(negedge clock);
        reset_n = 1'b1;
        repeat (3) begin
            @(posedge clock); #1;
            n_cmp++; if (bus.response_valid !== 1'b0) begin n_fail++; $display("FAIL rm_no_rsp: got %b want 0", bus.response_valid); end
        end
        n_cmp++; if (we_count - we0 !== 0) begin n_fail++; $display("FAIL rm_pulses: got %0d want 0", we_count - we0); end
        n_cmp++; if (mem[20] !== 32'h5566_7788) begin n_fail++; $display("FAIL rm_mem: got %h want 55667788", mem[20]); end
    endtask

    initial begin
        reset_n              = 1'b0;
        bus.request_valid    = 1'b0;
        bus.request_write    = 1'b0;
        bus.request_size     = 2'b00;
        bus.request_unsigned = 1'b0;
        bus.request_address  = '0;
        bus.request_data     = '0;
        bus.response_ready   = 1'b1;
        test_reset();
        test_word_store_load();
        test_subword_store();
        test_loads();
        test_misaligned();
        test_backpressure();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got no finish want finish");
        $fatal(1, "timeout");
    end

endmodule
